// File: rtl/ddr_rx_pkg.sv
// Shared constants for the HDR-DDR read path: RX mode codes, error codes and
// the read sequencer state encoding, plus small state-decode helpers.
package ddr_rx_pkg;

  localparam logic [3:0] RX_MODE_PREAMBLE        = 4'b0000;
  localparam logic [3:0] RX_MODE_DESERIALIZING   = 4'b0011;
  localparam logic [3:0] RX_MODE_CHECK_TOKEN     = 4'b0101;
  localparam logic [3:0] RX_MODE_CHECK_PAR_VALUE = 4'b0110;
  localparam logic [3:0] RX_MODE_CHECK_CRC_VALUE = 4'b0111;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_PREAMBLE = 3'd1;
  localparam logic [2:0] ERR_PARITY   = 3'd2;
  localparam logic [2:0] ERR_TOKEN    = 3'd3;
  localparam logic [2:0] ERR_CRC      = 3'd4;
  localparam logic [2:0] ERR_OVERFLOW = 3'd5;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd6;

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_PRE0   = 4'd1;
  localparam logic [3:0] ST_PRE1   = 4'd2;
  localparam logic [3:0] ST_BYTE0  = 4'd3;
  localparam logic [3:0] ST_CAP0   = 4'd4;
  localparam logic [3:0] ST_BYTE1  = 4'd5;
  localparam logic [3:0] ST_CAP1   = 4'd6;
  localparam logic [3:0] ST_PARITY = 4'd7;
  localparam logic [3:0] ST_TOKEN  = 4'd8;
  localparam logic [3:0] ST_CRC    = 4'd9;
  localparam logic [3:0] ST_DONE   = 4'd10;
  localparam logic [3:0] ST_ERR    = 4'd11;

  function automatic logic [3:0] rx_mode_of(input logic [3:0] st);
    case (st)
      ST_BYTE0, ST_CAP0, ST_BYTE1, ST_CAP1: rx_mode_of = RX_MODE_DESERIALIZING;
      ST_PARITY: rx_mode_of = RX_MODE_CHECK_PAR_VALUE;
      ST_TOKEN:  rx_mode_of = RX_MODE_CHECK_TOKEN;
      ST_CRC:    rx_mode_of = RX_MODE_CHECK_CRC_VALUE;
      default:   rx_mode_of = RX_MODE_PREAMBLE;
    endcase
  endfunction

  // States in which the RX block is running (and the transfer counts as busy).
  function automatic logic st_active(input logic [3:0] st);
    st_active = (st != ST_IDLE) && (st != ST_DONE) && (st != ST_ERR);
  endfunction

  // States that wait on i_rx_mode_done (watchdog-supervised).
  function automatic logic st_waiting(input logic [3:0] st);
    st_waiting = st_active(st) && (st != ST_CAP0) && (st != ST_CAP1);
  endfunction

endpackage

// File: rtl/ddr_rx_watchdog.sv
// Per-stage watchdog: counts cycles since the last clear and flags expiry at
// TIMEOUT_CYCLES-1; the count holds at that value until cleared.
module ddr_rx_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic i_sys_clk,
  input  logic i_sys_rst,
  input  logic i_clear,
  output logic o_expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_expired = (r_cnt == LIMIT);

  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst || i_clear) begin
      r_cnt <= '0;
    end else if (!o_expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ddr_rx_seq.sv
// HDR-DDR read-path sequencer driving the RX deserializer and register file.
// Optional per-stage watchdog enabled by defining DDR_RX_SEQ_TIMEOUT_EN.
module ddr_rx_seq
  import ddr_rx_pkg::*;
#(
  parameter int unsigned ADDR_W         = 6,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              i_sys_clk,
  input  logic              i_sys_rst,
  input  logic              i_engine_start,
  input  logic [ADDR_W-1:0] i_word_limit,
  input  logic [ADDR_W-1:0] i_base_addr,
  output logic              o_rx_en,
  output logic [3:0]        o_rx_mode,
  input  logic              i_rx_mode_done,
  input  logic              i_rx_pre,
  input  logic              i_rx_error,
  input  logic [7:0]        i_rx_data,
  output logic              o_regf_wr_en,
  output logic [ADDR_W-1:0] o_regf_addr,
  output logic [7:0]        o_regf_wr_data,
  output logic              o_busy,
  output logic              o_engine_done,
  output logic              o_engine_error,
  output logic [2:0]        o_error_code
);

  logic [3:0]        r_state;
  logic [3:0]        w_next;
  logic [2:0]        w_code;
  logic              r_armed;
  logic              r_pre0;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_word;
  logic [ADDR_W-1:0] w_addr;
  logic              w_timeout;

  // The first cycle after reset release never accepts a start.
  always_comb begin
    w_next = r_state;
    w_code = ERR_NONE;
    case (r_state)
      ST_IDLE:   if (i_engine_start && r_armed) w_next = ST_PRE0;
      ST_PRE0:   if (i_rx_mode_done) w_next = ST_PRE1;
      ST_PRE1: begin
        if (i_rx_mode_done) begin
          case ({r_pre0, i_rx_pre})
            2'b11: begin
              if (r_word == i_word_limit) begin
                w_next = ST_ERR;
                w_code = ERR_OVERFLOW;
              end else begin
                w_next = ST_BYTE0;
              end
            end
            2'b01:   w_next = ST_TOKEN;
            default: begin
              w_next = ST_ERR;
              w_code = ERR_PREAMBLE;
            end
          endcase
        end
      end
      ST_BYTE0:  if (i_rx_mode_done) w_next = ST_CAP0;
      ST_CAP0:   w_next = ST_BYTE1;
      ST_BYTE1:  if (i_rx_mode_done) w_next = ST_CAP1;
      ST_CAP1:   w_next = ST_PARITY;
      ST_PARITY: begin
        if (i_rx_mode_done) begin
          w_next = i_rx_error ? ST_ERR : ST_PRE0;
          w_code = i_rx_error ? ERR_PARITY : ERR_NONE;
        end
      end
      ST_TOKEN: begin
        if (i_rx_mode_done) begin
          w_next = i_rx_error ? ST_ERR : ST_CRC;
          w_code = i_rx_error ? ERR_TOKEN : ERR_NONE;
        end
      end
      ST_CRC: begin
        if (i_rx_mode_done) begin
          w_next = i_rx_error ? ST_ERR : ST_DONE;
          w_code = i_rx_error ? ERR_CRC : ERR_NONE;
        end
      end
      default:   w_next = ST_IDLE;
    endcase
    // A stage completion in the expiry cycle wins over the watchdog.
    if (w_timeout && st_waiting(r_state) && (w_next == r_state)) begin
      w_next = ST_ERR;
      w_code = ERR_TIMEOUT;
    end
  end

`ifdef DDR_RX_SEQ_TIMEOUT_EN
  ddr_rx_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .i_sys_clk (i_sys_clk),
    .i_sys_rst (i_sys_rst),
    .i_clear   (w_next != r_state),
    .o_expired (w_timeout)
  );
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
  assign w_timeout = 1'b0;
`endif

  assign w_addr = r_base + (r_word << 1) + {{(ADDR_W-1){1'b0}}, (r_state == ST_CAP1)};

  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst) begin
      r_state        <= ST_IDLE;
      r_armed        <= 1'b0;
      r_pre0         <= 1'b0;
      r_base         <= '0;
      r_word         <= '0;
      o_rx_en        <= 1'b0;
      o_rx_mode      <= RX_MODE_PREAMBLE;
      o_regf_wr_en   <= 1'b0;
      o_regf_addr    <= '0;
      o_regf_wr_data <= '0;
      o_busy         <= 1'b0;
      o_engine_done  <= 1'b0;
      o_engine_error <= 1'b0;
      o_error_code   <= ERR_NONE;
    end else begin
      r_state       <= w_next;
      r_armed       <= 1'b1;
      o_rx_en       <= st_active(w_next);
      o_busy        <= st_active(w_next);
      o_rx_mode     <= rx_mode_of(w_next);
      o_engine_done <= (w_next == ST_DONE) || (w_next == ST_ERR);
      o_regf_wr_en  <= 1'b0;
      if (r_state == ST_IDLE && w_next == ST_PRE0) begin
        r_base         <= i_base_addr;
        r_word         <= '0;
        o_engine_error <= 1'b0;
        o_error_code   <= ERR_NONE;
      end
      if (r_state == ST_PRE0 && i_rx_mode_done) r_pre0 <= i_rx_pre;
      if (r_state == ST_CAP0 || r_state == ST_CAP1) begin
        o_regf_wr_en   <= 1'b1;
        o_regf_addr    <= w_addr;
        o_regf_wr_data <= i_rx_data;
      end
      if (r_state == ST_PARITY && w_next == ST_PRE0) r_word <= r_word + 1'b1;
      if (w_next == ST_ERR && r_state != ST_ERR) begin
        o_engine_error <= 1'b1;
        o_error_code   <= w_code;
      end
    end
  end

endmodule
